// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: single-outstanding fetch FSM feeding the IF/ID register.
// Define IFU_PERF_CNT_EN to add the fetch/redirect/stall performance counters.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_write_en_i,
  input  logic        if_id_write_en_i,
  input  logic        if_id_flush_i,
  input  logic        take_branch_i,
  input  logic [31:0] branch_target_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] if_pc_o,
`ifdef IFU_PERF_CNT_EN
  output logic [31:0] fetch_count_o,
  output logic [31:0] redirect_count_o,
  output logic [31:0] stall_count_o,
`endif
  output logic        if_id_valid_o,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_instr_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_HOLD} state_t;

  state_t      r_state;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_req_pc;
  logic [31:0] r_hold_pc;
  logic [31:0] r_hold_instr;
  logic        r_discard;
  logic        r_if_id_valid;
  logic [31:0] r_if_id_pc;
  logic [31:0] r_if_id_instr;

  state_t      w_state_nxt;
  logic [31:0] w_fetch_pc_nxt;
  logic [31:0] w_req_pc_nxt;
  logic [31:0] w_hold_pc_nxt;
  logic [31:0] w_hold_instr_nxt;
  logic        w_discard_nxt;
  logic        w_deliver;
  logic [31:0] w_deliver_pc;
  logic [31:0] w_deliver_instr;
  logic        w_if_id_valid_nxt;
  logic [31:0] w_if_id_pc_nxt;
  logic [31:0] w_if_id_instr_nxt;
  logic        w_accept;
  logic        w_both_en;
  logic        w_unused_target_lsbs;

  assign w_accept  = (r_state == ST_REQ) && imem_ready_i;
  assign w_both_en = pc_write_en_i && if_id_write_en_i;
  // Redirect targets are forced word-aligned, so the low two bits are never used.
  assign w_unused_target_lsbs = ^branch_target_pc_i[1:0];

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    w_state_nxt       = r_state;
    w_fetch_pc_nxt    = r_fetch_pc;
    w_req_pc_nxt      = r_req_pc;
    w_hold_pc_nxt     = r_hold_pc;
    w_hold_instr_nxt  = r_hold_instr;
    w_discard_nxt     = r_discard;
    w_deliver         = 1'b0;
    w_deliver_pc      = r_req_pc;
    w_deliver_instr   = imem_rdata_i;

    case (r_state)
      ST_IDLE: w_state_nxt = ST_REQ;
      ST_REQ: begin
        if (w_accept) begin
          w_req_pc_nxt = r_fetch_pc;
          w_state_nxt  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid_i) begin
          if (r_discard) begin
            w_discard_nxt = 1'b0;
            w_state_nxt   = ST_REQ;
          end else if (w_both_en) begin
            w_deliver      = 1'b1;
            w_fetch_pc_nxt = r_req_pc + 32'd4;
            w_state_nxt    = ST_REQ;
          end else begin
            w_hold_pc_nxt    = r_req_pc;
            w_hold_instr_nxt = imem_rdata_i;
            w_state_nxt      = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (w_both_en) begin
          w_deliver       = 1'b1;
          w_deliver_pc    = r_hold_pc;
          w_deliver_instr = r_hold_instr;
          w_fetch_pc_nxt  = r_hold_pc + 32'd4;
          w_state_nxt     = ST_REQ;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // A redirect beats everything; a request still in flight must have its response dropped.
    if (take_branch_i) begin
      w_deliver        = 1'b0;
      w_fetch_pc_nxt   = {branch_target_pc_i[31:2], 2'b00};
      w_hold_pc_nxt    = 32'h0;
      w_hold_instr_nxt = 32'h0;
      if (((r_state == ST_WAIT) && !imem_rvalid_i) || w_accept) begin
        w_state_nxt   = ST_WAIT;
        w_discard_nxt = 1'b1;
      end else begin
        w_state_nxt   = ST_REQ;
        w_discard_nxt = 1'b0;
      end
    end

    w_if_id_valid_nxt = r_if_id_valid;
    w_if_id_pc_nxt    = r_if_id_pc;
    w_if_id_instr_nxt = r_if_id_instr;
    if (take_branch_i || if_id_flush_i) begin
      w_if_id_valid_nxt = 1'b0;
    end else if (if_id_write_en_i) begin
      w_if_id_valid_nxt = w_deliver;
      if (w_deliver) begin
        w_if_id_pc_nxt    = w_deliver_pc;
        w_if_id_instr_nxt = w_deliver_instr;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_fetch_pc    <= RESET_PC;
      r_req_pc      <= 32'h0;
      r_hold_pc     <= 32'h0;
      r_hold_instr  <= 32'h0;
      r_discard     <= 1'b0;
      r_if_id_valid <= 1'b0;
      r_if_id_pc    <= 32'h0;
      r_if_id_instr <= 32'h0;
    end else begin
      r_state       <= w_state_nxt;
      r_fetch_pc    <= w_fetch_pc_nxt;
      r_req_pc      <= w_req_pc_nxt;
      r_hold_pc     <= w_hold_pc_nxt;
      r_hold_instr  <= w_hold_instr_nxt;
      r_discard     <= w_discard_nxt;
      r_if_id_valid <= w_if_id_valid_nxt;
      r_if_id_pc    <= w_if_id_pc_nxt;
      r_if_id_instr <= w_if_id_instr_nxt;
    end
  end

  assign imem_req_o    = (r_state == ST_REQ);
  assign imem_addr_o   = r_fetch_pc;
  assign if_pc_o       = r_fetch_pc;
  assign if_id_valid_o = r_if_id_valid;
  assign if_id_pc_o    = r_if_id_pc;
  assign if_id_instr_o = r_if_id_instr;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_redirect_count;
  logic [31:0] r_stall_count;
  logic        w_fetch_load;

  // Counts only deliveries that actually land in IF/ID, not ones lost to a flush.
  assign w_fetch_load = w_deliver && if_id_write_en_i && !if_id_flush_i && !take_branch_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_count    <= 32'h0;
      r_redirect_count <= 32'h0;
      r_stall_count    <= 32'h0;
    end else begin
      if (w_fetch_load)          r_fetch_count    <= r_fetch_count + 32'd1;
      if (take_branch_i)         r_redirect_count <= r_redirect_count + 32'd1;
      if (r_state == ST_HOLD)    r_stall_count    <= r_stall_count + 32'd1;
    end
  end

  assign fetch_count_o    = r_fetch_count;
  assign redirect_count_o = r_redirect_count;
  assign stall_count_o    = r_stall_count;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: vector table for the start-up stream,
// hand-written sequences for hold, redirect, flush, back-pressure and reset-in-WAIT.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NONE = 32'hFFFF_FFFF;

  logic        clk;
  logic        rst_n;
  logic        pc_write_en;
  logic        if_id_write_en;
  logic        if_id_flush;
  logic        take_branch;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] redirect_count;
  logic [31:0] stall_count;
`endif

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .pc_write_en_i      (pc_write_en),
    .if_id_write_en_i   (if_id_write_en),
    .if_id_flush_i      (if_id_flush),
    .take_branch_i      (take_branch),
    .branch_target_pc_i (branch_target),
    .imem_req_o         (imem_req),
    .imem_addr_o        (imem_addr),
    .imem_ready_i       (imem_ready),
    .imem_rvalid_i      (imem_rvalid),
    .imem_rdata_i       (imem_rdata),
    .if_pc_o            (if_pc),
`ifdef IFU_PERF_CNT_EN
    .fetch_count_o      (fetch_count),
    .redirect_count_o   (redirect_count),
    .stall_count_o      (stall_count),
`endif
    .if_id_valid_o      (if_id_valid),
    .if_id_pc_o         (if_id_pc),
    .if_id_instr_o      (if_id_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Scoreboards: expected accepted addresses and expected IF/ID deliveries.
  logic [31:0] iss_q[$];
  logic [31:0] del_q[$];

  // Memory model state.
  logic        pend;
  logic [31:0] pend_addr;
  int          pend_cnt;
  int          mem_lat;
  logic [31:0] stall_addr;
  logic [31:0] resp_addr;
  logic        last_acc;
  logic [31:0] acc_addr;

  logic        prev_v;
  logic [31:0] prev_pc;
  logic [31:0] bad0;
  logic [31:0] bad1;

  typedef struct {
    logic        ready;
    logic        we;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;
  vec_t vecs[7];

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {~pc[15:0], pc[15:0]} ^ 32'h1357_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // One clock: memory accepts before the edge, responds and the monitor samples 1 time unit after.
  task automatic cycle();
    logic [31:0] exp_v;
    last_acc = imem_req && imem_ready;
    if (last_acc) begin
      acc_addr = imem_addr;
      if (iss_q.size() > 0) begin
        exp_v = iss_q.pop_front();
        check("issue_addr", imem_addr, exp_v);
      end
      pend      = 1'b1;
      pend_addr = imem_addr;
      pend_cnt  = mem_lat;
    end
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    if (pend && (pend_addr != stall_addr)) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        pend        = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = instr_of(pend_addr);
        resp_addr   = pend_addr;
      end
    end
    if (if_id_valid && (!prev_v || (if_id_pc != prev_pc))) begin
      if (del_q.size() > 0) begin
        exp_v = del_q.pop_front();
        check("deliver_pc", if_id_pc, exp_v);
      end
      check("deliver_instr", if_id_instr, instr_of(if_id_pc));
      check("forbidden_pc", 32'((if_id_pc == bad0) || (if_id_pc == bad1)), 32'd0);
    end
    prev_v  = if_id_valid;
    prev_pc = if_id_pc;
  endtask

  task automatic wait_acc(input logic [31:0] addr, input string name);
    logic found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      if (last_acc && (acc_addr == addr)) found = 1'b1;
    end
    check(name, 32'(found), 32'd1);
  endtask

  task automatic wait_resp(input logic [31:0] addr, input string name);
    logic found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      if (imem_rvalid && (resp_addr == addr)) found = 1'b1;
    end
    check(name, 32'(found), 32'd1);
  endtask

  task automatic wait_deliver(input logic [31:0] pc, input string name);
    logic found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      if (if_id_valid && (if_id_pc == pc)) found = 1'b1;
    end
    check(name, 32'(found), 32'd1);
  endtask

  task automatic wait_req(input string name);
    for (int i = 0; i < 40 && !imem_req; i++) cycle();
    check(name, 32'(imem_req), 32'd1);
  endtask

  initial begin
    // Start-up stream from reset, 1-cycle memory; expectations are post-edge samples.
    vecs[0] = '{1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h4, 1'b1, 32'h0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h4, 1'b0, 32'h0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h8, 1'b1, 32'h4};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h8, 1'b0, 32'h0};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 32'hC, 1'b1, 32'h8};

    rst_n = 1'b0;
    pc_write_en = 1'b1;
    if_id_write_en = 1'b1;
    if_id_flush = 1'b0;
    take_branch = 1'b0;
    branch_target = 32'h0;
    imem_ready = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    pend = 1'b0;
    pend_addr = 32'h0;
    pend_cnt = 0;
    mem_lat = 1;
    stall_addr = NONE;
    resp_addr = 32'h0;
    last_acc = 1'b0;
    acc_addr = 32'h0;
    prev_v = 1'b0;
    prev_pc = 32'h0;
    bad0 = NONE;
    bad1 = NONE;

    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_valid", 32'(if_id_valid), 32'd0);
    check("rst_pc", if_id_pc, 32'h0);
    check("rst_instr", if_id_instr, 32'h0);
    rst_n = 1'b1;

    // Basic in-order stream: 0, 4, 8.
    iss_q.push_back(32'h0); iss_q.push_back(32'h4); iss_q.push_back(32'h8);
    del_q.push_back(32'h0); del_q.push_back(32'h4); del_q.push_back(32'h8);
    for (int k = 0; k < 7; k++) begin
      imem_ready     = vecs[k].ready;
      if_id_write_en = vecs[k].we;
      pc_write_en    = vecs[k].we;
      cycle();
      check($sformatf("vec%0d_req", k), 32'(imem_req), 32'(vecs[k].exp_req));
      check($sformatf("vec%0d_addr", k), imem_addr, vecs[k].exp_addr);
      check($sformatf("vec%0d_valid", k), 32'(if_id_valid), 32'(vecs[k].exp_valid));
      if (vecs[k].exp_valid) check($sformatf("vec%0d_pc", k), if_id_pc, vecs[k].exp_pc);
    end

    // Response for 0x10 arrives while IF/ID is stalled for 3 cycles.
    iss_q.push_back(32'hC); iss_q.push_back(32'h10); iss_q.push_back(32'h14);
    del_q.push_back(32'hC); del_q.push_back(32'h10);
    wait_resp(32'h10, "resp_0x10_seen");
    if_id_write_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check($sformatf("hold%0d_req", k), 32'(imem_req), 32'd0);
      check($sformatf("hold%0d_addr", k), imem_addr, 32'h10);
    end
    if_id_write_en = 1'b1;
    cycle();
    check("hold_release_valid", 32'(if_id_valid), 32'd1);
    check("hold_release_pc", if_id_pc, 32'h10);
    check("hold_release_next_addr", imem_addr, 32'h14);
    check("hold_release_req", 32'(imem_req), 32'd1);
`ifdef IFU_PERF_CNT_EN
    check("stall_count", stall_count, 32'd3);
`endif

    // Redirect while the 0x20 response is still outstanding.
    iss_q.push_back(32'h18); iss_q.push_back(32'h1C); iss_q.push_back(32'h20);
    del_q.push_back(32'h14); del_q.push_back(32'h18); del_q.push_back(32'h1C);
    stall_addr = 32'h20;
    wait_acc(32'h20, "acc_0x20_seen");
    bad0 = 32'h20;
    take_branch = 1'b1;
    branch_target = 32'h103;
    cycle();
    take_branch = 1'b0;
    check("br_valid", 32'(if_id_valid), 32'd0);
    check("br_req_waiting", 32'(imem_req), 32'd0);
    check("br_addr", imem_addr, 32'h100);
    stall_addr = NONE;
    cycle();
    cycle();
    check("br_drop_req", 32'(imem_req), 32'd1);
    check("br_drop_addr", imem_addr, 32'h100);
    check("br_drop_valid", 32'(if_id_valid), 32'd0);
    iss_q.push_back(32'h100);
    del_q.push_back(32'h100);
    wait_deliver(32'h100, "deliver_0x100_seen");
`ifdef IFU_PERF_CNT_EN
    check("fetch_count", fetch_count, 32'd9);
    check("redirect_count_1", redirect_count, 32'd1);
`endif

    // Flush with IF/ID holding a valid entry, then flush against a same-cycle delivery.
    iss_q.push_back(32'h104); iss_q.push_back(32'h108); iss_q.push_back(32'h10C);
    del_q.push_back(32'h104); del_q.push_back(32'h10C);
    if_id_write_en = 1'b0;
    if_id_flush = 1'b1;
    cycle();
    if_id_flush = 1'b0;
    if_id_write_en = 1'b1;
    check("flush_hold_valid", 32'(if_id_valid), 32'd0);
    check("flush_hold_addr", imem_addr, 32'h104);
    bad1 = 32'h108;
    wait_resp(32'h108, "resp_0x108_seen");
    if_id_flush = 1'b1;
    cycle();
    if_id_flush = 1'b0;
    check("flush_deliver_valid", 32'(if_id_valid), 32'd0);
    check("flush_deliver_addr", imem_addr, 32'h10C);
    check("flush_deliver_req", 32'(imem_req), 32'd1);
    wait_deliver(32'h10C, "deliver_0x10c_seen");

    // Back-pressure: ready low for 4 cycles at 0x40.
    wait_req("req_before_bp");
    imem_ready = 1'b0;
    take_branch = 1'b1;
    branch_target = 32'h40;
    cycle();
    take_branch = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check($sformatf("bp%0d_req", k), 32'(imem_req), 32'd1);
      check($sformatf("bp%0d_addr", k), imem_addr, 32'h40);
      check($sformatf("bp%0d_acc", k), 32'(last_acc), 32'd0);
    end
    imem_ready = 1'b1;
    iss_q.push_back(32'h40);
    del_q.push_back(32'h40);
    cycle();
    check("bp_accept", 32'(last_acc), 32'd1);
`ifdef IFU_PERF_CNT_EN
    check("redirect_count_2", redirect_count, 32'd2);
`endif
    wait_deliver(32'h40, "deliver_0x40_seen");

    // Reset while waiting on 0x44; its late response must be ignored.
    stall_addr = 32'h44;
    wait_acc(32'h44, "acc_0x44_seen");
    rst_n = 1'b0;
    #1;
    check("rst2_req", 32'(imem_req), 32'd0);
    check("rst2_addr", imem_addr, 32'h0);
    check("rst2_valid", 32'(if_id_valid), 32'd0);
    check("rst2_pc", if_id_pc, 32'h0);
    check("rst2_instr", if_id_instr, 32'h0);
`ifdef IFU_PERF_CNT_EN
    check("rst2_fetch_count", fetch_count, 32'd0);
    check("rst2_stall_count", stall_count, 32'd0);
`endif
    stall_addr = NONE;
    cycle();
    rst_n = 1'b1;
    check("stray_idle_req", 32'(imem_req), 32'd0);
    cycle();
    check("stray_ignored_req", 32'(imem_req), 32'd1);
    check("stray_ignored_addr", imem_addr, 32'h0);
    check("stray_ignored_valid", 32'(if_id_valid), 32'd0);
    iss_q.push_back(32'h0);
    del_q.push_back(32'h0);
    wait_deliver(32'h0, "deliver_restart_seen");

    check("iss_q_drained", 32'(iss_q.size()), 32'd0);
    check("del_q_drained", 32'(del_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have clk  input  1  single clock; every register updates on the rising edge.
REQ-003 SHALL have rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have pc_write_en_i  input  1  PC advance enable from hazard control.
REQ-005 SHALL have if_id_write_en_i  input  1  IF/ID load enable; 0 means hold.
REQ-006 SHALL have if_id_flush_i  input  1  IF/ID invalidate.
REQ-007 SHALL have take_branch_i  input  1  redirect request.
REQ-008 SHALL have branch_target_pc_i  input  32  redirect address.
REQ-009 SHALL have imem_req_o  output  1  fetch request valid.
REQ-010 SHALL have imem_addr_o  output  32  fetch address.
REQ-011 SHALL have imem_ready_i  input  1  request accepted when imem_req_o and imem_ready_i are both 1.
REQ-012 SHALL have imem_rvalid_i  input  1  response valid, exactly one per accepted request, at least 1 cycle after acceptance.
REQ-013 SHALL have imem_rdata_i  input  32  response instruction.
REQ-014 SHALL have if_pc_o  output  32  current fetch PC, for hazard control.
REQ-015 SHALL have if_id_valid_o, if_id_pc_o, if_id_instr_o  output  1/32/32  IF/ID pipeline register contents.

Function
REQ-016 SHALL hold fetch_pc; if_pc_o and imem_addr_o SHALL both equal fetch_pc.
REQ-017 SHALL implement states IDLE, REQ, WAIT and HOLD; IDLE SHALL last exactly one cycle after reset release and then go to REQ.
REQ-018 In REQ, imem_req_o SHALL be 1; on acceptance, fetch_pc SHALL be latched into req_pc and the state SHALL go to WAIT; otherwise it SHALL stay in REQ with imem_addr_o stable.
REQ-019 imem_req_o SHALL be 0 outside REQ; at most one request SHALL be outstanding.
REQ-020 In WAIT, with rvalid, discard=0, pc_write_en_i=1 and if_id_write_en_i=1: IF/ID SHALL load {1, req_pc, rdata}, fetch_pc SHALL become req_pc+4 (mod 2^32), and the state SHALL go to REQ.
REQ-021 In WAIT, with rvalid, discard=0 and either enable 0: rdata/req_pc SHALL go to the hold buffer and the state SHALL go to HOLD.
REQ-022 In HOLD, when both enables are 1: IF/ID SHALL load the hold buffer, fetch_pc SHALL become req_pc+4, and the state SHALL go to REQ.
REQ-023 When if_id_write_en_i=1 and no instruction is delivered that cycle, if_id_valid_o SHALL become 0 (bubble); when 0, all IF/ID outputs SHALL hold.
REQ-024 take_branch_i SHALL have priority over every other event: fetch_pc SHALL become {branch_target_pc_i[31:2],2'b00}, if_id_valid_o SHALL become 0, and the hold buffer SHALL be dropped.
REQ-025 On redirect, the next state SHALL be REQ, except WAIT with no rvalid that cycle, or REQ with acceptance that same cycle; those two SHALL go to WAIT with discard=1.
REQ-026 In WAIT with discard=1, rvalid SHALL drop the data, clear discard, and go to REQ with no IF/ID change.
REQ-027 A redirect while discard=1 SHALL keep discard=1 and update fetch_pc.
REQ-028 if_id_flush_i without take_branch_i SHALL clear if_id_valid_o next cycle, overriding any same-cycle delivery (which is lost, and fetch_pc still advances); FSM state and fetch_pc SHALL otherwise be unaffected.
REQ-029 imem_rvalid_i outside WAIT SHALL be ignored.
REQ-030 Best-case latency: request accepted in cycle N, rvalid in N+1, if_id_valid_o=1 in N+2; the next request SHALL issue in N+2.

Reset
REQ-031 While rst_n=0, asynchronously: state=IDLE, fetch_pc=RESET_PC, imem_req_o=0, if_id_valid_o=0, if_id_pc_o=0, if_id_instr_o=0, req_pc=0, hold buffer=0, discard=0.
REQ-032 Reset during WAIT SHALL abandon the outstanding request; its late rvalid SHALL be ignored per REQ-029.

Configuration
REQ-033 Macro IFU_PERF_CNT_EN: when defined, SHALL add 32-bit wrapping outputs fetch_count_o (IF/ID loads with valid=1), redirect_count_o (take_branch_i cycles) and stall_count_o (cycles in HOLD), all reset to 0; when undefined, these ports and their logic SHALL be absent, with all other behaviour identical.

Verification
REQ-034 Bench SHALL run: reset, RESET_PC=0, ready=1, 1-cycle memory -> addresses 0,4,8 issued; IF/ID shows pc 0,4,8 with matching instr.
REQ-035 Bench SHALL run: rvalid with pc 0x10 while if_id_write_en_i=0 for 3 cycles -> HOLD; stall_count_o=3; IF/ID loads 0x10 once enables return; next request is 0x14.
REQ-036 Bench SHALL run: take_branch_i with target 0x103 while WAIT on 0x20 -> the 0x20 response is dropped; next request 0x100; IF/ID never shows 0x20.
REQ-037 Bench SHALL run: if_id_flush_i alone while if_id_valid_o=1 -> valid=0 next cycle; fetch sequence unchanged.
REQ-038 Bench SHALL run: imem_ready_i=0 for 4 cycles at 0x40 -> imem_req_o and imem_addr_o=0x40 held stable; accepted on cycle 5.
REQ-039 Bench SHALL run: rst_n pulsed low in WAIT, then a stray rvalid -> outputs at reset values; stray rvalid ignored; fetch restarts at RESET_PC.
